regs_seq: RTL and testbench

Self-test initiator for the 32×32 two-read-port register file. On a Start pulse it writes a selectable pattern to all 32 addresses, reads every address back through both read ports, and counts mismatches. It drives the register file's write and read address ports directly, and summarises the pass/fail result on the board's 8 LEDs.

---
 rtl/regs_seq_if.sv | 23 ++
 rtl/regs_seq.sv | 160 ++++++++++++++++
 tb/tb_regs_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regs_seq_if.sv
// Register-file access bus between the self-test sequencer and a 32x32
// register file with one write port and two combinational read ports.
interface regs_seq_if;
    logic        Write_reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;

    // Sequencer side: drives write/read addresses, consumes read data
    modport master (
        output Write_reg, W_Addr, W_Data, R_Addr_A, R_Addr_B,
        input  R_Data_A, R_Data_B
    );

    // Register-file side
    modport slave (
        input  Write_reg, W_Addr, W_Data, R_Addr_A, R_Addr_B,
        output R_Data_A, R_Data_B
    );
endinterface

// File: rtl/regs_seq.sv
// Register-file self-test sequencer: writes a selectable pattern to every
// address, reads all addresses back through both ports (A ascending, B
// descending), counts mismatches with saturation and shows the result on LEDs.
module regs_seq #(
    parameter int N_REGS = 32,
    parameter int ERR_W  = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       PAT_SEL,
    regs_seq_if.master       rf,
    output logic             Busy,
    output logic             Done,
    output logic [ERR_W-1:0] Err_Cnt,
    output logic [4:0]       Fail_Addr,
    output logic [7:0]       LED
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [4:0]   LAST    = 5'(N_REGS - 1);
    localparam logic [ERR_W:0] ERR_MAX = {1'b0, {ERR_W{1'b1}}};

    state_t           state_reg, state_next;
    logic [4:0]       idx_reg, idx_next;
    logic [1:0]       pat_reg, pat_next;
    logic [ERR_W-1:0] err_reg, err_next;
    logic [4:0]       fail_addr_reg, fail_addr_next;
    logic             first_reg, first_next;

    logic [4:0]       addr_b;
    logic             mism_a, mism_b;
    logic [ERR_W:0]   err_sum;
    logic [5:0]       err_led;

    // Test pattern for address a under pattern select sel
    function automatic logic [31:0] pattern(input logic [1:0] sel, input logic [4:0] a);
        logic [31:0] ax;
        ax = {27'd0, a};
        case (sel)
            2'b00:   pattern = ax;
            2'b01:   pattern = ~ax;
            2'b10:   pattern = 32'h1 << a;
            default: pattern = 32'h8000_1111 ^ ax;
        endcase
    endfunction

    assign addr_b  = LAST - idx_reg;
    assign mism_a  = (rf.R_Data_A != pattern(pat_reg, idx_reg));
    assign mism_b  = (rf.R_Data_B != pattern(pat_reg, addr_b));
    assign err_sum = {1'b0, err_reg} + (ERR_W+1)'(mism_a) + (ERR_W+1)'(mism_b);

    // The LED field is always six bits wide regardless of the counter width
    generate
        if (ERR_W >= 6) begin : g_led_trunc
            assign err_led = err_reg[5:0];
        end else begin : g_led_ext
            assign err_led = {{(6-ERR_W){1'b0}}, err_reg};
        end
    endgenerate

    // State and datapath registers; reset returns everything to IDLE immediately
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            pat_reg       <= '0;
            err_reg       <= '0;
            fail_addr_reg <= '0;
            first_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            pat_reg       <= pat_next;
            err_reg       <= err_next;
            fail_addr_reg <= fail_addr_next;
            first_reg     <= first_next;
        end
    end

    // Next-state logic: walk WRITE then READ, accumulate mismatches in READ
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        pat_next       = pat_reg;
        err_next       = err_reg;
        fail_addr_next = fail_addr_reg;
        first_next     = first_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (Start) begin
                    pat_next       = PAT_SEL;
                    err_next       = '0;
                    fail_addr_next = '0;
                    first_next     = 1'b0;
                    idx_next       = '0;
                    state_next     = WRITE;
                end
            end
            WRITE: begin
                if (idx_reg == LAST) begin
                    idx_next   = '0;
                    state_next = READ;
                end else begin
                    idx_next = idx_reg + 5'd1;
                end
            end
            READ: begin
                err_next = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
                // Port A wins when both ports miss on the first failing cycle
                if (!first_reg && (mism_a || mism_b)) begin
                    first_next     = 1'b1;
                    fail_addr_next = mism_a ? idx_reg : addr_b;
                end
                if (idx_reg == LAST) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; buses are zero outside their active state
    always_comb begin
        rf.Write_reg = 1'b0;
        rf.W_Addr    = '0;
        rf.W_Data    = '0;
        rf.R_Addr_A  = '0;
        rf.R_Addr_B  = '0;
        Busy         = 1'b0;
        Done         = 1'b0;
        LED          = 8'h00;
        case (state_reg)
            WRITE: begin
                rf.Write_reg = 1'b1;
                rf.W_Addr    = idx_reg;
                rf.W_Data    = pattern(pat_reg, idx_reg);
                Busy         = 1'b1;
                LED          = {3'b010, idx_reg};
            end
            READ: begin
                rf.R_Addr_A = idx_reg;
                rf.R_Addr_B = addr_b;
                Busy        = 1'b1;
                LED         = {3'b010, idx_reg};
            end
            DONE: begin
                Done = 1'b1;
                LED  = {(err_reg == '0), (err_reg != '0), err_led};
            end
            default: ;
        endcase
    end

    assign Err_Cnt   = err_reg;
    assign Fail_Addr = fail_addr_reg;
endmodule

// File: tb/tb_regs_seq.sv
// Bench for regs_seq: a behavioural register file with optional faults
// (stuck bit at one address, or all reads returning zero) plus an expected
// result computed from the pattern rules over all 32 addresses.
module tb_regs_seq;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] PAT_SEL;
    logic       Busy, Done;
    logic [5:0] Err_Cnt;
    logic [4:0] Fail_Addr;
    logic [7:0] LED;

    regs_seq_if bus();

    regs_seq #(.N_REGS(32), .ERR_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .PAT_SEL(PAT_SEL),
        .rf(bus), .Busy(Busy), .Done(Done), .Err_Cnt(Err_Cnt),
        .Fail_Addr(Fail_Addr), .LED(LED)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Register-file model and fault configuration
    logic [31:0] mem [32];
    int          f_mode = 0;   // 0 fault-free, 1 one bit forced, 2 reads return zero
    logic [4:0]  f_addr = '0;
    int          f_bit  = 0;
    logic        f_val  = 1'b0;

    function automatic logic [31:0] fault(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (f_mode == 2) r = 32'd0;
        else if (f_mode == 1 && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always_ff @(posedge Clk) begin
        if (bus.Write_reg) mem[bus.W_Addr] <= bus.W_Data;
    end

    always_comb begin
        bus.R_Data_A = fault(bus.R_Addr_A, mem[bus.R_Addr_A]);
        bus.R_Data_B = fault(bus.R_Addr_B, mem[bus.R_Addr_B]);
    end

    function automatic logic [31:0] pat(input logic [1:0] s, input int a);
        case (s)
            2'd0:    return 32'(a);
            2'd1:    return ~32'(a);
            2'd2:    return 32'h1 << a;
            default: return 32'h8000_1111 ^ 32'(a);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " write_reg"}, 32'(bus.Write_reg), 0);
        chk({tag, " w_addr"}, 32'(bus.W_Addr), 0);
        chk({tag, " w_data"}, bus.W_Data, 0);
        chk({tag, " r_addr_a"}, 32'(bus.R_Addr_A), 0);
        chk({tag, " r_addr_b"}, 32'(bus.R_Addr_B), 0);
        chk({tag, " busy"}, 32'(Busy), 0);
        chk({tag, " done"}, 32'(Done), 0);
        chk({tag, " err_cnt"}, 32'(Err_Cnt), 0);
        chk({tag, " fail_addr"}, 32'(Fail_Addr), 0);
        chk({tag, " led"}, 32'(LED), 0);
    endtask

    // One self-test run; poke pulses Start at WRITE idx 10 and READ idx 3,
    // rst_at >= 0 asserts Reset in WRITE at that index and abandons the run.
    task automatic run(input logic [1:0] sel, input bit poke, input int rst_at);
        int         e = 0;
        int         fa = 0;
        bit         got = 0;
        bit         ma, mb;
        logic [5:0] exp_err;
        logic [7:0] exp_led;

        // Expected outcome: every address read once on each port
        for (int i = 0; i < 32; i++) begin
            ma = (fault(5'(i), pat(sel, i)) != pat(sel, i));
            mb = (fault(5'(31 - i), pat(sel, 31 - i)) != pat(sel, 31 - i));
            e += int'(ma) + int'(mb);
            if (!got && (ma || mb)) begin
                got = 1;
                fa  = ma ? i : 31 - i;
            end
        end
        exp_err = (e > 63) ? 6'd63 : 6'(e);
        exp_led = {(exp_err == 0), (exp_err != 0), exp_err};

        @(negedge Clk);
        Start   = 1'b1;
        PAT_SEL = sel;
        @(negedge Clk);
        Start   = 1'b0;
        PAT_SEL = 2'($urandom_range(0, 3));

        for (int c = 0; c < 64; c++) begin
            if (c == rst_at) begin
                Reset = 1'b0;
                #1;
                chk_all_zero("midrun reset");
                @(negedge Clk);
                chk_all_zero("held reset");
                Reset = 1'b1;
                $display("run sel=%0d aborted by reset at write idx %0d", sel, c);
                return;
            end
            chk("busy", 32'(Busy), 1);
            chk("done during run", 32'(Done), 0);
            if (c < 32) begin
                chk("write_reg", 32'(bus.Write_reg), 1);
                chk("w_addr", 32'(bus.W_Addr), 32'(c));
                chk("w_data", bus.W_Data, pat(sel, c));
                chk("r_addr_a in write", 32'(bus.R_Addr_A), 0);
                chk("r_addr_b in write", 32'(bus.R_Addr_B), 0);
                chk("err_cnt cleared", 32'(Err_Cnt), 0);
                chk("fail_addr cleared", 32'(Fail_Addr), 0);
                chk("led write", 32'(LED), 32'({3'b010, 5'(c)}));
            end else begin
                chk("write_reg in read", 32'(bus.Write_reg), 0);
                chk("w_addr in read", 32'(bus.W_Addr), 0);
                chk("w_data in read", bus.W_Data, 0);
                chk("r_addr_a", 32'(bus.R_Addr_A), 32'(c - 32));
                chk("r_addr_b", 32'(bus.R_Addr_B), 32'(31 - (c - 32)));
                chk("led read", 32'(LED), 32'({3'b010, 5'(c - 32)}));
            end
            Start = poke && (c == 10 || c == 35);
            @(negedge Clk);
        end
        Start = 1'b0;

        chk("done", 32'(Done), 1);
        chk("busy at done", 32'(Busy), 0);
        chk("write_reg at done", 32'(bus.Write_reg), 0);
        chk("err_cnt", 32'(Err_Cnt), 32'(exp_err));
        chk("fail_addr", 32'(Fail_Addr), 32'(fa));
        chk("led done", 32'(LED), 32'(exp_led));
        $display("run sel=%0d fault=%0d poke=%0d err=%0d fail_addr=%0d led=%02h",
                 sel, f_mode, poke, Err_Cnt, Fail_Addr, LED);

        // Result holds while idle
        repeat ($urandom_range(0, 3)) @(negedge Clk);
        chk("done held", 32'(Done), 1);
        chk("err_cnt held", 32'(Err_Cnt), 32'(exp_err));
        chk("fail_addr held", 32'(Fail_Addr), 32'(fa));
    endtask

    initial begin
        Reset   = 1'b0;
        Start   = 1'b0;
        PAT_SEL = 2'b00;
        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        Reset = 1'b1;
        @(negedge Clk);
        chk_all_zero("idle");

        // Fault-free walking-one pattern
        f_mode = 0;
        run(2'b10, 1'b0, -1);

        // Bit 3 of address 5 forced high: misses on A at idx 5 and B at idx 26
        f_mode = 1; f_addr = 5'd5; f_bit = 3; f_val = 1'b1;
        run(2'b11, 1'b0, -1);

        // All reads zero under inverted pattern: 64 misses, counter saturates
        f_mode = 2;
        run(2'b01, 1'b0, -1);

        // Restart straight from a failing DONE with a clean register file
        f_mode = 0;
        run(2'b00, 1'b0, -1);

        // Start pulses while busy are ignored
        run(2'($urandom_range(0, 3)), 1'b1, -1);

        // Reset in the middle of WRITE, then a complete run
        run(2'($urandom_range(0, 3)), 1'b0, 17);
        run(2'($urandom_range(0, 3)), 1'b0, -1);

        // Randomised fault configurations and patterns
        for (int t = 0; t < 6; t++) begin
            f_mode = $urandom_range(0, 2);
            f_addr = 5'($urandom_range(0, 31));
            f_bit  = $urandom_range(0, 31);
            f_val  = 1'($urandom_range(0, 1));
            run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
